// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the Mini SRC hardwired control sequencer:
// opcodes, state encoding and opcode classes.
package cpu_ctrl_pkg;
   localparam int ALU_OP_W = 5;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RESET = 4'd0,
      ST_T0    = 4'd1,
      ST_T1    = 4'd2,
      ST_T2    = 4'd3,
      ST_T3    = 4'd4,
      ST_T4    = 4'd5,
      ST_T5    = 4'd6,
      ST_T6    = 4'd7,
      ST_HALT  = 4'd8
   } state_e;

   typedef enum logic [2:0] {
      CL_ALU2,
      CL_MULDIV,
      CL_UNARY,
      CL_NOP,
      CL_HALT
   } op_class_e;
endpackage

// File: rtl/control_unit_if.sv
// Control strobes from the sequencer to the datapath, plus the IR and
// stop request fed back to the sequencer.
interface control_unit_if import cpu_ctrl_pkg::*; ();
   logic [31:0]         ir;
   logic                Stop;
   logic                PCout, Zlowout, Zhighout, MDRout;
   logic                MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
   logic                IncPC, Read;
   logic                Gra, Grb, Grc, Rin, Rout;
   logic [ALU_OP_W-1:0] alu_op;
   logic                run;

   modport master (
      input  ir, Stop,
      output PCout, Zlowout, Zhighout, MDRout,
      output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
      output IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, run
   );

   modport slave (
      output ir, Stop,
      input  PCout, Zlowout, Zhighout, MDRout,
      input  MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
      input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, run
   );
endinterface

// File: rtl/op_class_decode.sv
// Maps an instruction opcode to the execute-sequence class it follows.
module op_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] opcode,
   output op_class_e  op_class
);
   always_comb begin
      op_class = CL_NOP;
      case (opcode)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL,
         OP_ROR, OP_ROL, OP_AND, OP_OR:  op_class = CL_ALU2;
         OP_MUL, OP_DIV:                 op_class = CL_MULDIV;
         OP_NEG, OP_NOT:                 op_class = CL_UNARY;
         OP_HALT:                        op_class = CL_HALT;
         default:                        op_class = CL_NOP;
      endcase
   end
endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: fetch, decode and one control
// state per clock, with outputs decoded from the present state and opcode.
//
//   state | meaning
//   RESET | held by clear, all outputs 0
//   T0    | PC to MAR, PC+4 into Z
//   T1    | Z to PC, memory read into MDR
//   T2    | MDR to IR
//   T3-T6 | execute steps, depend on opcode class
//   HALT  | idle until clear, all outputs 0
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic           Clock,
   input  logic           clear,
   control_unit_if.master bus
);
   state_e    state, state_next, instr_end;
   op_class_e op_class;
   logic [4:0] opcode;

   assign opcode = bus.ir[31:27];

   op_class_decode u_op_class_decode (
      .opcode   (opcode),
      .op_class (op_class)
   );

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) state <= ST_RESET;
      else        state <= state_next;
   end

   // Stop only matters on the edge that leaves the last state of an instruction.
   assign instr_end = bus.Stop ? ST_HALT : ST_T0;

   always_comb begin
      state_next = state;
      case (state)
         ST_RESET: state_next = ST_T0;
         ST_T0:    state_next = ST_T1;
         ST_T1:    state_next = ST_T2;
         ST_T2:    state_next = ST_T3;
         ST_T3: begin
            case (op_class)
               CL_ALU2, CL_MULDIV, CL_UNARY: state_next = ST_T4;
               CL_HALT:                      state_next = ST_HALT;
               default:                      state_next = instr_end;
            endcase
         end
         ST_T4:    state_next = (op_class == CL_UNARY)  ? instr_end : ST_T5;
         ST_T5:    state_next = (op_class == CL_MULDIV) ? ST_T6 : instr_end;
         ST_T6:    state_next = instr_end;
         ST_HALT:  state_next = ST_HALT;
         default:  state_next = ST_RESET;
      endcase
   end

   always_comb begin
      bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.MDRout = 1'b0;
      bus.MARin = 1'b0; bus.Zin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0;
      bus.IRin = 1'b0; bus.Yin = 1'b0; bus.LOin = 1'b0; bus.HIin = 1'b0;
      bus.IncPC = 1'b0; bus.Read = 1'b0;
      bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
      bus.alu_op = '0;
      bus.run = (state != ST_RESET) && (state != ST_HALT);
      case (state)
         ST_T0: begin
            bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
         end
         ST_T1: begin
            bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
         end
         ST_T2: begin
            bus.MDRout = 1'b1; bus.IRin = 1'b1;
         end
         ST_T3: begin
            if (op_class == CL_ALU2 || op_class == CL_MULDIV) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end else if (op_class == CL_UNARY) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
            end
         end
         ST_T4: begin
            if (op_class == CL_UNARY) begin
               bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else begin
               bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
            end
         end
         ST_T5: begin
            bus.Zlowout = 1'b1;
            if (op_class == CL_MULDIV) bus.LOin = 1'b1;
            else begin
               bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
         end
         ST_T6: begin
            bus.Zhighout = 1'b1; bus.HIin = 1'b1;
         end
         default: ;
      endcase
      // The ALU sees the opcode for the whole execute phase.
      if (state == ST_T3 || state == ST_T4 || state == ST_T5 || state == ST_T6)
         bus.alu_op = opcode;
   end
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random
// instruction streams compared against a per-opcode strobe-sequence model.
module tb_control_unit;
   typedef logic [24:0] vec_t;

   localparam vec_t M_PCOUT    = vec_t'(1) << 24;
   localparam vec_t M_ZLOWOUT  = vec_t'(1) << 23;
   localparam vec_t M_ZHIGHOUT = vec_t'(1) << 22;
   localparam vec_t M_MDROUT   = vec_t'(1) << 21;
   localparam vec_t M_MARIN    = vec_t'(1) << 20;
   localparam vec_t M_ZIN      = vec_t'(1) << 19;
   localparam vec_t M_PCIN     = vec_t'(1) << 18;
   localparam vec_t M_MDRIN    = vec_t'(1) << 17;
   localparam vec_t M_IRIN     = vec_t'(1) << 16;
   localparam vec_t M_YIN      = vec_t'(1) << 15;
   localparam vec_t M_LOIN     = vec_t'(1) << 14;
   localparam vec_t M_HIIN     = vec_t'(1) << 13;
   localparam vec_t M_INCPC    = vec_t'(1) << 12;
   localparam vec_t M_READ     = vec_t'(1) << 11;
   localparam vec_t M_GRA      = vec_t'(1) << 10;
   localparam vec_t M_GRB      = vec_t'(1) << 9;
   localparam vec_t M_GRC      = vec_t'(1) << 8;
   localparam vec_t M_RIN      = vec_t'(1) << 7;
   localparam vec_t M_ROUT     = vec_t'(1) << 6;
   localparam vec_t M_RUN      = vec_t'(1);

   logic Clock;
   logic clear;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t exp_q[$];
   logic [4:0] op_list [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                5'b01000, 5'b01010, 5'b01011, 5'b01111, 5'b10000,
                                5'b10001, 5'b10010, 5'b11010, 5'b11011};

   control_unit_if cu_if ();

   control_unit dut (
      .Clock (Clock),
      .clear (clear),
      .bus   (cu_if)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   function automatic vec_t obs();
      return {cu_if.PCout, cu_if.Zlowout, cu_if.Zhighout, cu_if.MDRout, cu_if.MARin,
              cu_if.Zin, cu_if.PCin, cu_if.MDRin, cu_if.IRin, cu_if.Yin, cu_if.LOin,
              cu_if.HIin, cu_if.IncPC, cu_if.Read, cu_if.Gra, cu_if.Grb, cu_if.Grc,
              cu_if.Rin, cu_if.Rout, cu_if.alu_op, cu_if.run};
   endfunction

   // 0 alu2, 1 muldiv, 2 unary, 3 nop, 4 halt
   function automatic int cls_of(logic [4:0] op);
      if ((op >= 5'd3 && op <= 5'd8) || op == 5'd10 || op == 5'd11) return 0;
      if (op == 5'd15 || op == 5'd16) return 1;
      if (op == 5'd17 || op == 5'd18) return 2;
      if (op == 5'd27) return 4;
      return 3;
   endfunction

   task automatic build_exp(input logic [4:0] op);
      vec_t a;
      a = vec_t'(op) << 1;
      exp_q.delete();
      exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
      exp_q.push_back(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN);
      exp_q.push_back(M_MDROUT | M_IRIN | M_RUN);
      case (cls_of(op))
         0: begin
            exp_q.push_back(M_GRB | M_ROUT | M_YIN | M_RUN | a);
            exp_q.push_back(M_GRC | M_ROUT | M_ZIN | M_RUN | a);
            exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN | M_RUN | a);
         end
         1: begin
            exp_q.push_back(M_GRB | M_ROUT | M_YIN | M_RUN | a);
            exp_q.push_back(M_GRC | M_ROUT | M_ZIN | M_RUN | a);
            exp_q.push_back(M_ZLOWOUT | M_LOIN | M_RUN | a);
            exp_q.push_back(M_ZHIGHOUT | M_HIIN | M_RUN | a);
         end
         2: begin
            exp_q.push_back(M_GRB | M_ROUT | M_ZIN | M_RUN | a);
            exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN | M_RUN | a);
         end
         default: exp_q.push_back(M_RUN | a);
      endcase
   endtask

   // Called just after a negedge; leaves RESET so the next posedge enters T0.
   task automatic pulse_clear();
      #2 clear = 1'b0;
      #1 clear = 1'b1;
   endtask

   task automatic test_reset();
      clear = 1'b0;
      cu_if.ir = 32'h0;
      cu_if.Stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         n_tests++;
         if (obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: got %h want 0", i, obs());
         end
      end
      clear = 1'b1;
   endtask

   task automatic test_instr(input string name, input logic [31:0] ir_val, input int expect_len);
      build_exp(ir_val[31:27]);
      n_tests++;
      if (exp_q.size() != expect_len) begin
         n_fail++;
         $display("FAIL %s_len: model %0d want %0d", name, exp_q.size(), expect_len);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge Clock);
         if (i == 0) begin cu_if.ir = ir_val; cu_if.Stop = 1'b0; end
         n_tests++;
         if (obs() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s step T%0d: got %h want %h", name, i, obs(), exp_q[i]);
         end
      end
      @(negedge Clock);
      n_tests++;
      if (obs() !== (M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN)) begin
         n_fail++;
         $display("FAIL %s_return_t0: got %h", name, obs());
      end
      @(posedge Clock);
      @(negedge Clock);
      n_tests++;
      if (obs() !== (M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN)) begin
         n_fail++;
         $display("FAIL %s_next_t1: got %h", name, obs());
      end
      // Drain the next fetch as a nop so the following test starts at T0.
      cu_if.ir = 32'hD0000000;
      @(negedge Clock);
      @(negedge Clock);
   endtask

   task automatic test_halt();
      build_exp(5'b11011);
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         if (i == 0) begin cu_if.ir = 32'hD8000000; cu_if.Stop = 1'b0; end
         n_tests++;
         if (obs() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL halt step T%0d: got %h want %h", i, obs(), exp_q[i]);
         end
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         n_tests++;
         if (obs() !== '0) begin
            n_fail++;
            $display("FAIL halt_idle cycle %0d: got %h want 0", i, obs());
         end
      end
      pulse_clear();
      @(negedge Clock);
      n_tests++;
      if (obs() !== (M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN)) begin
         n_fail++;
         $display("FAIL halt_restart_t0: got %h", obs());
      end
      cu_if.ir = 32'hD0000000;
      @(negedge Clock);
      @(negedge Clock);
      @(negedge Clock);
   endtask

   task automatic test_stop();
      build_exp(5'b01010);
      for (int i = 0; i < 6; i++) begin
         @(negedge Clock);
         if (i == 0) begin cu_if.ir = 32'h50918000; cu_if.Stop = 1'b0; end
         n_tests++;
         if (obs() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL stop step T%0d: got %h want %h", i, obs(), exp_q[i]);
         end
         if (i == 4) cu_if.Stop = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         n_tests++;
         if (obs() !== '0) begin
            n_fail++;
            $display("FAIL stop_halt cycle %0d: got %h want 0", i, obs());
         end
      end
      cu_if.Stop = 1'b0;
      pulse_clear();
   endtask

   task automatic test_clear_mid();
      build_exp(5'b01010);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         if (i == 0) begin cu_if.ir = 32'h50918000; cu_if.Stop = 1'b0; end
         n_tests++;
         if (obs() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL clear_mid step T%0d: got %h want %h", i, obs(), exp_q[i]);
         end
      end
      #2 clear = 1'b0;
      #1;
      n_tests++;
      if (obs() !== '0) begin
         n_fail++;
         $display("FAIL clear_mid_async: got %h want 0", obs());
      end
      clear = 1'b1;
      @(negedge Clock);
      n_tests++;
      if (obs() !== (M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN)) begin
         n_fail++;
         $display("FAIL clear_mid_restart_t0: got %h", obs());
      end
      cu_if.ir = 32'hD0000000;
      @(negedge Clock);
      @(negedge Clock);
      @(negedge Clock);
   endtask

   task automatic test_random(input int n_instr);
      logic [4:0]  op;
      logic [31:0] ir_val;
      logic        stop;
      bit          halted;
      for (int k = 0; k < n_instr; k++) begin
         if ($urandom_range(0, 15) < 14) op = op_list[$urandom_range(0, 13)];
         else                            op = 5'($urandom_range(0, 31));
         ir_val = {op, 27'($urandom())};
         stop = ($urandom_range(0, 9) == 0);
         halted = stop || (cls_of(op) == 4);
         build_exp(op);
         for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge Clock);
            if (i == 0) begin cu_if.ir = ir_val; cu_if.Stop = stop; end
            n_tests++;
            if (obs() !== exp_q[i]) begin
               n_fail++;
               $display("FAIL rand #%0d op %b T%0d: got %h want %h", k, op, i, obs(), exp_q[i]);
            end
         end
         if (halted) begin
            for (int i = 0; i < 2; i++) begin
               @(negedge Clock);
               n_tests++;
               if (obs() !== '0) begin
                  n_fail++;
                  $display("FAIL rand_halt #%0d cycle %0d: got %h want 0", k, i, obs());
               end
            end
            cu_if.Stop = 1'b0;
            pulse_clear();
         end
      end
   endtask

   initial begin
      test_reset();
      test_instr("and", 32'h50918000, 6);
      test_instr("mul", 32'h78118000, 7);
      test_instr("not", 32'h92280000, 5);
      test_instr("nop", 32'hD0000000, 4);
      test_halt();
      test_stop();
      test_clear_mid();
      test_random(300);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
